mult_div_unit: RTL
==================

# mult_div_unit

HI/LO multiply–divide unit for the MIPS datapath. It sits directly downstream of the register file: it consumes the two register read ports (rs on `operand_a`, rt on `operand_b`) and holds the architectural HI and LO registers that MFHI/MFLO read. Multiplies complete in one cycle. Divides run an iterative 33-cycle sequence and report `busy` so the control unit can stall.

## Interface
- Parameters: none. Data width is fixed at 32.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  requests the operation on `op`; sampled on the rising edge.
- `op`  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `operand_a`  in  32  rs value: multiplicand, dividend, or the MTHI/MTLO source.
- `operand_b`  in  32  rt value: multiplier or divisor.
- `busy`  out  1  divide in progress; the CPU must stall MFHI/MFLO and further mult/div ops.
- `hi`  out  32  HI register: product[63:32] or remainder.
- `lo`  out  32  LO register: product[31:0] or quotient.

## Operation
- A request is accepted when `start`=1 and `busy`=0 at a rising edge.
  - `start` while `busy`=1 is ignored: no state change and no queueing.
  - The operands are captured only at acceptance; later changes on the inputs have no effect.
- MULT: 64-bit signed product of the operands. `hi` gets bits [63:32] and `lo` gets bits [31:0].
- MULTU: same as MULT, unsigned.
- MTHI: `hi` <= `operand_a`; `lo` unchanged.
- MTLO: `lo` <= `operand_a`; `hi` unchanged.
- DIV/DIVU results: `lo` <= quotient, `hi` <= remainder.
  - DIVU is plain unsigned division.
  - DIV: divide the magnitudes. Negate the quotient if the operand signs differ. The remainder takes the sign of the dividend (truncating division).
- Divide by zero (both DIV and DIVU):
  - `lo` = 0xFFFFFFFF.
  - `hi` = dividend as captured: raw `operand_a` for DIVU, the original signed dividend for DIV.
- DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0. This falls out of the 32-bit wraparound in the sign fix-up.
- State machine states:
  - IDLE: accepts requests.
  - DIVIDE: 5-bit counter, 32 restoring shift-subtract iterations, one quotient bit per cycle.
  - FIXUP: applies sign correction and the divide-by-zero override, then writes `hi`/`lo`.
- Transitions:
  - IDLE -> DIVIDE on an accepted DIV/DIVU.
  - DIVIDE -> FIXUP when the counter reaches 31.
  - FIXUP -> IDLE always.
- Internal registers:
  - partial remainder: 33 bits.
  - dividend/quotient shift register: 32 bits.
  - divisor magnitude: 32 bits.
  - sign flags: 2.
  - divide-by-zero flag: 1.
  - saved dividend: 32 bits.
- `hi` and `lo` hold their values during a divide and change only at FIXUP.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, state=IDLE, counter=0.
- Reset during a divide aborts it. The outputs return to their reset values on the next edge and the result is never written.
- MULT/MULTU/MTHI/MTLO accepted at edge N: the result is visible after edge N. `busy` stays 0.
- DIV/DIVU accepted at edge N:
  - `busy`=1 after edge N.
  - DIVIDE occupies edges N+1..N+32 and FIXUP is edge N+33.
  - After edge N+33: `busy`=0 and `hi`/`lo` hold the result.
  - `busy` is high for exactly 33 cycles.
- A new request may be accepted on the edge immediately after `busy` falls (edge N+34).
- `busy` is registered and is not driven combinationally from `start`.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 -> next cycle `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE; `busy` never rises.
- MULTU 0xFFFFFFFF × 0x00000002 -> `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIVU 100 / 7 -> `busy` high for exactly 33 cycles, then `lo`=14, `hi`=2.
- Signed cases:
  - DIV 0xFFFFFFF9 (−7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Divide by zero:
  - DIVU 0x12345678 / 0 -> `lo`=0xFFFFFFFF, `hi`=0x12345678.
  - Assert MTLO with `start` mid-divide -> ignored; `lo` holds 0xFFFFFFFF afterwards.
- Reset mid-operation: MTHI 0xDEADBEEF, then DIVU 50/5, then `reset` for one cycle at cycle 10 of the divide -> `busy`=0, `hi`=`lo`=0. A subsequent MULTU 3×4 gives `lo`=12, `hi`=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/result bundle for the HI/LO multiply-divide unit.
// The CPU side drives master; mult_div_unit takes slave.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO and a 33-cycle
// restoring DIV/DIVU (32 shift-subtract steps plus one sign fix-up cycle).
module mult_div_unit (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StDivide, StFixup} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] divisor_q;
  logic [31:0] dividend_q;
  logic        quot_neg_q;
  logic        rem_neg_q;
  logic        div_zero_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] product;
  logic [33:0] diff;
  logic        step_ge;
  logic [31:0] fix_quo;
  logic [31:0] fix_rem;

  always_comb begin
    signed_div = (bus.op == OpDiv);
    a_neg      = signed_div & bus.operand_a[31];
    b_neg      = signed_div & bus.operand_b[31];
    a_mag      = a_neg ? -bus.operand_a : bus.operand_a;
    b_mag      = b_neg ? -bus.operand_b : bus.operand_b;
    // Low 64 bits of the extended product are correct for both signednesses.
    mul_a_ext  = {{32{(bus.op == OpMult) & bus.operand_a[31]}}, bus.operand_a};
    mul_b_ext  = {{32{(bus.op == OpMult) & bus.operand_b[31]}}, bus.operand_b};
    product    = mul_a_ext * mul_b_ext;
    // Trial subtract one bit wider than the shifted remainder so bit 33 is the borrow.
    diff       = {rem_q, quo_q[31]} - {2'b00, divisor_q};
    step_ge    = ~diff[33];
    fix_quo    = quot_neg_q ? -quo_q : quo_q;
    fix_rem    = rem_neg_q ? -rem_q[31:0] : rem_q[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            case (bus.op)
              OpMult, OpMultu: begin
                hi_q <= product[63:32];
                lo_q <= product[31:0];
              end
              OpDiv, OpDivu: begin
                quo_q      <= a_mag;
                divisor_q  <= b_mag;
                rem_q      <= '0;
                quot_neg_q <= a_neg ^ b_neg;
                rem_neg_q  <= a_neg;
                div_zero_q <= (bus.operand_b == 32'd0);
                dividend_q <= bus.operand_a;
                cnt_q      <= '0;
                busy_q     <= 1'b1;
                state_q    <= StDivide;
              end
              OpMthi:  hi_q <= bus.operand_a;
              OpMtlo:  lo_q <= bus.operand_a;
              default: ;
            endcase
          end
        end
        StDivide: begin
          if (step_ge) begin
            rem_q <= diff[32:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= {rem_q[31:0], quo_q[31]};
            quo_q <= {quo_q[30:0], 1'b0};
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= StFixup;
          end
        end
        StFixup: begin
          lo_q    <= div_zero_q ? 32'hFFFF_FFFF : fix_quo;
          hi_q    <= div_zero_q ? dividend_q : fix_rem;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
